// File: rtl/memory_stage_pkg.sv
// Shared definitions for the MEM stage.
//   - memory address select encodings (ADDR_*)
//   - memory write-source select encodings (WSRC_*)
//   - two-state sequencer enum used for 32-bit PC push/pop
package memory_stage_pkg;

  localparam logic [1:0] ADDR_RESULT   = 2'b00;
  localparam logic [1:0] ADDR_SP       = 2'b01;
  localparam logic [1:0] ADDR_SP_PLUS1 = 2'b10;

  localparam logic [1:0] WSRC_RD1   = 2'b00;
  localparam logic [1:0] WSRC_PC    = 2'b01;
  localparam logic [1:0] WSRC_FLAGS = 2'b10;

  typedef enum logic {
    IDLE   = 1'b0,
    SECOND = 1'b1
  } state_t;

endpackage

// File: rtl/memory_stage_stack_pointer_unit.sv
// Stack pointer register for the MEM stage. The stack grows down from
// STACK_TOP; all arithmetic wraps modulo 2**ADDR_W.
// Ports:
//   clk_i      - clock, rising edge
//   rst_ni     - asynchronous active-low reset, SP returns to STACK_TOP
//   inc_i      - pop: SP <= SP + 1
//   dec_i      - push: SP <= SP - 1 (wins over inc_i)
//   sp_o       - current SP
//   sp_plus1_o - SP + 1, the address a pop reads from
module stack_pointer_unit #(
  parameter int unsigned       ADDR_W    = 12,
  parameter logic [ADDR_W-1:0] STACK_TOP = {ADDR_W{1'b1}}
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              inc_i,
  input  logic              dec_i,
  output logic [ADDR_W-1:0] sp_o,
  output logic [ADDR_W-1:0] sp_plus1_o
);

  logic [ADDR_W-1:0] sp_q, sp_d;

  always_comb begin
    sp_d = sp_q;
    if (dec_i) begin
      sp_d = sp_q - 1'b1;
    end else if (inc_i) begin
      sp_d = sp_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sp_q <= STACK_TOP;
    end else begin
      sp_q <= sp_d;
    end
  end

  assign sp_o       = sp_q;
  assign sp_plus1_o = sp_q + 1'b1;

endmodule

// File: rtl/var_reg.sv
// Generic enabled register with asynchronous active-low clear.
// Ports:
//   clk_i  - clock, rising edge
//   rst_ni - asynchronous active-low reset, clears the register to 0
//   en_i   - load enable
//   d_i    - next value
//   q_o    - registered value
module var_reg #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] data_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= '0;
    end else if (en_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/memory_stage.sv
// MEM stage of the 5-stage pipeline. Drives the 16-bit word-addressed data
// memory from the EX/MEM buffer, owns the stack pointer, sequences 32-bit
// PC push/pop as two word accesses (one upstream stall, one bubble), and
// registers the result into the MEM/WB buffer.
// Ports:
//   clk, reset (async, active-low)
//   EX/MEM inputs : result_in, read_data1, read_data2, pc_plus_one, flags_in,
//                   mem_read/mem_write/mem_push/mem_pop, address and write-source
//                   selects, pc_choose_memory, flag_restore, pass-through fields
//   memory port   : mem_addr, mem_wdata, mem_we (combinational), mem_rdata (async)
//   stall_out     : hold EX/MEM and upstream this cycle
//   MEM/WB outputs: mem_data_out, result_out, pass-throughs, popped PC/flags
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 12,
  parameter logic [ADDR_W-1:0] STACK_TOP = {ADDR_W{1'b1}}
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       result_in,
  input  logic [15:0]       read_data1,
  input  logic [15:0]       read_data2,
  input  logic [31:0]       pc_plus_one,
  input  logic [2:0]        flags_in,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              mem_push,
  input  logic              mem_pop,
  input  logic [1:0]        memory_address_select,
  input  logic [1:0]        memory_write_src_select,
  input  logic              pc_choose_memory,
  input  logic              flag_restore,
  input  logic [1:0]        wb_sel,
  input  logic              reg_write,
  input  logic [2:0]        reg_write_address,
  input  logic              outport_enable,
  input  logic [15:0]       LDM_value,
  input  logic [15:0]       input_port,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              mem_we,
  input  logic [15:0]       mem_rdata,
  output logic              stall_out,
  output logic [15:0]       mem_data_out,
  output logic [15:0]       result_out,
  output logic [15:0]       LDM_value_out,
  output logic [15:0]       input_port_out,
  output logic [1:0]        wb_sel_out,
  output logic              reg_write_out,
  output logic [2:0]        reg_write_address_out,
  output logic              outport_enable_out,
  output logic [31:0]       pc_from_memory_out,
  output logic              pc_choose_memory_out,
  output logic [2:0]        conditions_from_memory_pop,
  output logic              flag_restore_out
);

  localparam int unsigned WB_W = 16 * 4 + 2 + 1 + 3 + 1 + 1 + 1;

  state_t            state_q, state_d;
  logic [15:0]       hold_q, hold_d;
  logic [ADDR_W-1:0] sp, sp_plus1;
  logic              push_eff, pop_eff;
  logic              wide_push, wide_pop;
  logic              first_half, second_half;
  logic              pc_pop_done, flag_pop_done;
  logic [WB_W-1:0]   wb_d, wb_q;
  logic              unused_rd2;

  // read_data2 is part of the EX/MEM bundle but no MEM-stage path uses it.
  assign unused_rd2 = ^read_data2;

  // Push beats pop when both are requested.
  assign push_eff  = mem_push;
  assign pop_eff   = mem_pop & ~mem_push;
  assign wide_push = push_eff & (memory_write_src_select == WSRC_PC);
  assign wide_pop  = pop_eff & pc_choose_memory;

  // First half of a wide op: stall upstream and send a bubble down.
  assign first_half  = (state_q == IDLE)   & (wide_push | wide_pop);
  assign second_half = (state_q == SECOND) & (wide_push | wide_pop);

  // Gated by reset so that asserting reset drops the stall and any write
  // immediately, without waiting for a clock.
  assign stall_out = reset & first_half;
  assign mem_we    = reset & (push_eff | mem_write);

  always_comb begin
    mem_addr = result_in[ADDR_W-1:0];
    case (memory_address_select)
      ADDR_SP:       mem_addr = sp;
      ADDR_SP_PLUS1: mem_addr = sp_plus1;
      default:       mem_addr = result_in[ADDR_W-1:0];
    endcase
  end

  // A wide push writes the high half first (at the higher address) so a
  // pop naturally returns the low half first.
  always_comb begin
    mem_wdata = read_data1;
    case (memory_write_src_select)
      WSRC_PC:    mem_wdata = (state_q == IDLE && wide_push) ? pc_plus_one[31:16]
                                                             : pc_plus_one[15:0];
      WSRC_FLAGS: mem_wdata = {13'b0, flags_in};
      default:    mem_wdata = read_data1;
    endcase
  end

  always_comb begin
    state_d = first_half ? SECOND : IDLE;
    hold_d  = (first_half & wide_pop) ? mem_rdata : hold_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  stack_pointer_unit #(
    .ADDR_W    (ADDR_W),
    .STACK_TOP (STACK_TOP)
  ) u_sp (
    .clk_i      (clk),
    .rst_ni     (reset),
    .inc_i      (pop_eff),
    .dec_i      (push_eff),
    .sp_o       (sp),
    .sp_plus1_o (sp_plus1)
  );

  // MEM/WB buffer.
  assign pc_pop_done   = second_half & wide_pop;
  assign flag_pop_done = pop_eff & flag_restore & ~first_half;

  assign wb_d = {mem_rdata, result_in, LDM_value, input_port, wb_sel,
                 reg_write & ~first_half, reg_write_address,
                 outport_enable & ~first_half, pc_pop_done, flag_pop_done};

  var_reg #(.W(WB_W)) u_wb_reg (
    .clk_i  (clk),
    .rst_ni (reset),
    .en_i   (1'b1),
    .d_i    (wb_d),
    .q_o    (wb_q)
  );

  assign {mem_data_out, result_out, LDM_value_out, input_port_out, wb_sel_out,
          reg_write_out, reg_write_address_out, outport_enable_out,
          pc_choose_memory_out, flag_restore_out} = wb_q;

  // Popped PC and flags hold their value until the next pop of that kind;
  // the *_out valid bits qualify them.
  var_reg #(.W(32)) u_pc_reg (
    .clk_i  (clk),
    .rst_ni (reset),
    .en_i   (pc_pop_done),
    .d_i    ({mem_rdata, hold_q}),
    .q_o    (pc_from_memory_out)
  );

  var_reg #(.W(3)) u_flag_reg (
    .clk_i  (clk),
    .rst_ni (reset),
    .en_i   (flag_pop_done),
    .d_i    (mem_rdata[2:0]),
    .q_o    (conditions_from_memory_pop)
  );

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- MEM stage of the 5-stage pipeline, directly downstream of the execute stage.
- Consumes the EX/MEM buffer outputs (ALU result, operands, control bits) and drives the 16-bit word-addressed data memory.
- Owns the stack pointer (SP) and sequences 32-bit PC push/pop (CALL/RET/INT/RTI) as two word accesses, stalling upstream for one cycle.
- Registers everything into the MEM/WB buffer.

Parameters:
- ADDR_W, 12, data-memory word address width.
- STACK_TOP, 2**ADDR_W-1, SP reset value (stack grows down).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- result_in  in  16  ALU result (effective address / data).
- read_data1  in  16  Rdest value.
- read_data2  in  16  Rsrc value.
- pc_plus_one  in  32  return address for push.
- flags_in  in  3  {C,N,Z} for INT push.
- mem_read, mem_write, mem_push, mem_pop  in  1 each  access controls.
- memory_address_select  in  2  00 result_in, 01 SP, 10 SP+1, 11 treated as 00.
- memory_write_src_select  in  2  00 read_data1, 01 pc_plus_one (32-bit), 10 {13'b0,flags_in}, 11 treated as 00.
- pc_choose_memory  in  1  pop is a 32-bit PC pop.
- flag_restore  in  1  pop targets flags.
- wb_sel, reg_write, reg_write_address, outport_enable, LDM_value, input_port  in  2/1/3/1/16/16  pass-through.
- mem_addr  out  ADDR_W  memory address (combinational).
- mem_wdata  out  16  write data (combinational).
- mem_we  out  1  write enable (memory writes on rising clk).
- mem_rdata  in  16  asynchronous read data.
- stall_out  out  1  hold EX/MEM and upstream for this cycle.
- mem_data_out, result_out, LDM_value_out, input_port_out  out  16 each  MEM/WB.
- wb_sel_out, reg_write_out, reg_write_address_out, outport_enable_out  out  2/1/3/1  MEM/WB.
- pc_from_memory_out  out  32  popped PC.
- pc_choose_memory_out  out  1  popped PC valid.
- conditions_from_memory_pop  out  3  popped flags.
- flag_restore_out  out  1  popped flags valid.

Behaviour:
- Reset (reset=0, async):
  - FSM=IDLE, SP=STACK_TOP.
  - All registered outputs 0; stall_out=0.
  - Reset mid two-word op aborts it; the partial write stays in memory.
- FSM has two states, IDLE and SECOND.
  - A wide op is push with src=01, or pop with pc_choose_memory=1.
- IDLE, single-word op:
  - One cycle; mem_addr per select (result_in[ADDR_W-1:0], SP or SP+1).
  - Push: mem_we=1 at SP; SP<=SP-1.
  - Pop: read at SP+1; SP<=SP+1.
  - mem_read: read at mem_addr. mem_write: write at mem_addr.
  - MEM/WB captures mem_rdata and all pass-throughs at the edge.
- IDLE, wide push:
  - Write pc_plus_one[31:16] at SP; SP<=SP-1.
  - stall_out=1; MEM/WB loads a bubble (reg_write_out, outport_enable_out, pc_choose_memory_out, flag_restore_out = 0); go SECOND.
- SECOND, wide push:
  - Write pc_plus_one[15:0] at SP; SP<=SP-1.
  - stall_out=0; MEM/WB captures the real op; go IDLE.
- Wide pop:
  - IDLE reads low half at SP+1, SP++, latches it into an internal hold register, stalls, issues a bubble.
  - SECOND reads high half at SP+1, SP++.
  - pc_from_memory_out={high,low}; pc_choose_memory_out=1 for that one result cycle.
- Flag pop (flag_restore=1): conditions_from_memory_pop<=mem_rdata[2:0], flag_restore_out=1.
- Boundary and conflict rules:
  - SP arithmetic is mod 2^ADDR_W (wraps, no fault).
  - mem_push and mem_pop both set: push wins, pop ignored.
  - mem_read and mem_write both set: write wins; mem_data_out = mem_rdata pre-write.
  - Inputs are held stable by upstream while stall_out=1; the block re-samples them in SECOND.
- Latency: single-word ops 1 cycle to MEM/WB; wide ops 2 cycles, with one bubble.

Decomposition:
- Shared package holds:
  - address-select encodings ADDR_RESULT/ADDR_SP/ADDR_SP_PLUS1;
  - write-source encodings WSRC_RD1/WSRC_PC/WSRC_FLAGS;
  - FSM state enum {IDLE, SECOND}.
- One natural sub-module: stack_pointer_unit (SP register with inc/dec/reset-to-STACK_TOP).
- MEM/WB buffers use the existing var_reg.

Test Plan:
- Reset release → SP=0xFFF, all outputs 0. mem_read with result_in=0x0010 and memory[0x10]=0xBEEF → next cycle mem_data_out=0xBEEF, stall_out never 1.
- Push read_data1=0x1234 → memory[0xFFF]=0x1234, SP=0xFFE. Pop → mem_data_out=0x1234, SP=0xFFF.
- CALL: push pc_plus_one=0x0001_0020 → stall_out high exactly 1 cycle; memory[0xFFF]=0x0001, [0xFFE]=0x0020; SP=0xFFD; one bubble then valid result.
- RET right after → pc_from_memory_out=0x0001_0020 and pc_choose_memory_out=1 for one cycle; SP=0xFFF.
- SP=0x000 and pop → SP wraps to 0x001? No: pop from SP=0xFFF reads 0x000 and wraps SP to 0x000; push at SP=0x000 writes 0x000 and sets SP=0xFFF.
- reset low during SECOND of a CALL → FSM IDLE, SP=0xFFF, stall_out=0 immediately; push+pop both set → only push occurs.
